pe_os_mac: RTL
==============

Name: pe_os_mac

Overview:
- Parametrised output-stationary systolic processing element; next-generation PE for the matrix-multiply array.
- Forwards A operands east and B operands south with a valid/last sideband, and accumulates the A*B products locally.
- At the end of each tile, moves the result into a one-entry hold buffer and drains it down a ready/valid result chain shared by the column.
- Tiles run back-to-back with no bubble.

Parameters:
- DATA_W, 16, operand width in bits (two's complement when SIGNED=1).
- ACC_W, 40, accumulator/result width; must be >= 2*DATA_W.
- SIGNED, 1, 1 = signed multiply and sign-extend; 0 = unsigned multiply and zero-extend.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand pair valid this cycle.
- in_last  in  1  qualifies in_valid: final operand pair of the tile.
- in_a  in  DATA_W  A operand from west.
- in_b  in  DATA_W  B operand from north.
- out_valid  out  1  registered in_valid, to the east/south neighbours.
- out_last  out  1  registered in_last.
- out_a  out  DATA_W  registered in_a, to east.
- out_b  out  DATA_W  registered in_b, to south.
- res_in_valid  in  1  result from the PE above.
- res_in_data  in  ACC_W  result from the PE above.
- res_in_ready  out  1  this PE accepts res_in_data.
- res_out_valid  out  1  result toward the PE below or the collector.
- res_out_data  out  ACC_W  result toward the PE below or the collector.
- res_out_ready  in  1  downstream accepts the result.
- err_ovf  out  1  sticky: a tile result was lost.

Behaviour:
- Reset values: all outputs 0, including res_in_ready; accumulator 0, hold buffer empty, err_ovf 0. Reset mid-tile discards the partial sum and any pending or in-flight results.
- Forward path:
  - out_a/out_b/out_valid/out_last are in_a/in_b/in_valid/in_last delayed by exactly 1 cycle.
  - Data registers load every cycle regardless of valid.
- Multiply: prod = in_a*in_b at full 2*DATA_W, extended to ACC_W per SIGNED. Combinational; accumulation is registered.
- Accumulator FSM (states ACC, FLUSH):
  - ACC, in_valid & !in_last: acc <= acc + prod (wraps modulo 2^ACC_W).
  - ACC, in_valid & in_last: sum = acc + prod. Next cycle hold <= sum, hold_full <= 1, acc <= 0, and the FSM passes through FLUSH for that single cycle.
  - FLUSH: a valid input in this cycle accumulates from 0, so consecutive tiles have no bubble. Return to ACC.
  - in_valid=0: acc holds.
  - in_last without in_valid is ignored.
- Hold overflow: if in_valid & in_last arrives while hold_full and the hold is not being transferred this cycle:
  - the new sum is dropped and the hold keeps the old result;
  - acc still clears;
  - err_ovf <= 1 until rst.
- Output slot, single register (res_out_valid/res_out_data):
  - The slot may load when empty or when res_out_valid & res_out_ready.
  - Load priority: local hold first, then upstream.
  - res_in_ready = slot may load & !hold_full (combinational from state and res_out_ready only, never from res_in_valid).
  - A hold transfer clears hold_full in the same edge. If a new last completes in that same cycle, the new sum enters the hold (no error).
  - res_out_data must stay stable while res_out_valid & !res_out_ready.
- Latencies:
  - last operand to hold_full: 1 cycle; hold to res_out_valid: +1 cycle if the slot is free.
  - upstream accept to res_out_valid: 1 cycle.

Optional Feature:
- PE_SAT_EN defined:
  - accumulate and the last-sum saturate to the ACC_W range: signed min/max when SIGNED=1; 0 / 2^ACC_W-1 when SIGNED=0;
  - a saturation event also sets sticky err_ovf.
- PE_SAT_EN undefined: modulo wrap; err_ovf is set only by hold overflow.

Decomposition:
- Package pe_pkg holds:
  - the FSM state enum (ACC, FLUSH);
  - the default width constants DATA_W_DEF=16, ACC_W_DEF=40;
  - the function sat_add(a, b, signed) used under PE_SAT_EN.
- One natural sub-module: pe_res_slot, the one-entry ready/valid result register with local/upstream priority mux. The MAC and FSM stay in the top.

Test Plan:
- rst=1 for 2 cycles, then in_valid pairs (3,3),(2,-4),(5,1) with last on the third → hold=9-8+5=6 one cycle after last; res_out_data=6 next cycle; out_a/out_b trail inputs by 1 cycle.
- Back-to-back tiles, res_out_ready=1: tile1 (1,1),(1,1)last, tile2 (2,2)last on the immediately following cycle → results 2 then 4 on consecutive valid cycles; no bubble and no err_ovf.
- res_out_ready=0 with slot and hold full, then a third tile completes → err_ovf=1, hold keeps the second result; after ready=1, only results 1 and 2 emerge.
- Upstream res_in_valid=1 with data 0x77 while the local hold is full → local result out first, res_in_ready=0 until the hold empties, then 0x77. res_out_data stable throughout stalls.
- SIGNED=1: repeated (0x7FFF,0x7FFF) for 300 cycles with ACC_W=32 → without PE_SAT_EN wraps modulo 2^32; with PE_SAT_EN clamps at 0x7FFFFFFF and err_ovf=1.
- Assert rst mid-tile after 2 operands, release, run tile (4,4)last → result 16; no stale partial sum, no stale result, err_ovf=0.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and helpers for the output-stationary MAC processing element.
// sat_add is only referenced when PE_SAT_EN is defined.
package pe_pkg;

  typedef enum logic {
    ACC   = 1'b0,
    FLUSH = 1'b1
  } acc_state_e;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ACC_W_DEF  = 40;

  // Fixed working width for the saturating adder; callers extend into it.
  localparam int unsigned   SAT_W   = 64;
  localparam logic [SAT_W:0] SAT_ONE = {{SAT_W{1'b0}}, 1'b1};

  typedef struct packed {
    logic             sat;
    logic [SAT_W-1:0] sum;
  } sat_res_t;

  // a and b arrive sign- or zero-extended from w bits; the sum clamps to the
  // w-bit range and comes back extended the same way.
  function automatic sat_res_t sat_add(input logic [SAT_W-1:0] a,
                                       input logic [SAT_W-1:0] b,
                                       input logic             is_signed,
                                       input int unsigned      w);
    logic [SAT_W:0] full;
    logic [SAT_W:0] hi;
    logic [SAT_W:0] lo;
    sat_res_t       r;
    r.sat = 1'b0;
    lo    = '0;
    if (is_signed) begin
      full = {a[SAT_W-1], a} + {b[SAT_W-1], b};
      hi   = (SAT_ONE << (w - 1)) - SAT_ONE;
      lo   = ~hi;
      if ($signed(full) > $signed(hi)) begin
        r.sat = 1'b1;
        full  = hi;
      end else if ($signed(full) < $signed(lo)) begin
        r.sat = 1'b1;
        full  = lo;
      end
    end else begin
      full = {1'b0, a} + {1'b0, b};
      hi   = (SAT_ONE << w) - SAT_ONE;
      if (full > hi) begin
        r.sat = 1'b1;
        full  = hi;
      end
    end
    r.sum = full[SAT_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/pe_os_mac_res_slot.sv
// One-entry ready/valid result register shared down the column; the local
// hold buffer wins over the upstream PE whenever both are offering.
module pe_res_slot
  import pe_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             loc_valid,
  input  logic [ACC_W-1:0] loc_data,
  output logic             loc_take,
  input  logic             up_valid,
  input  logic [ACC_W-1:0] up_data,
  output logic             up_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  input  logic             out_ready
);

  logic live;
  logic can_load;

  assign can_load = !out_valid || out_ready;
  assign loc_take = can_load && loc_valid;
  // live keeps up_ready low while in reset and for the first cycle after.
  assign up_ready = live && can_load && !loc_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      live      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      live <= 1'b1;
      if (can_load) begin
        if (loc_valid) begin
          out_valid <= 1'b1;
          out_data  <= loc_data;
        end else if (up_valid && up_ready) begin
          out_valid <= 1'b1;
          out_data  <= up_data;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/pe_os_mac.sv
// Output-stationary systolic MAC PE: forwards operands east/south, accumulates
// A*B per tile, drains results down the column. PE_SAT_EN selects saturation.
module pe_os_mac
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  output logic              out_last,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  input  logic              res_in_valid,
  input  logic [ACC_W-1:0]  res_in_data,
  output logic              res_in_ready,
  output logic              res_out_valid,
  output logic [ACC_W-1:0]  res_out_data,
  input  logic              res_out_ready,
  output logic              err_ovf
);

  localparam int unsigned PW = 2 * DATA_W;

  acc_state_e       state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] hold;
  logic [ACC_W-1:0] prod;
  logic [PW-1:0]    a_x;
  logic [PW-1:0]    b_x;
  logic [PW-1:0]    prod_w;
  logic             hold_full;
  logic             hold_take;
  logic             sum_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
    end else begin
      out_valid <= in_valid;
      out_last  <= in_last;
      out_a     <= in_a;
      out_b     <= in_b;
    end
  end

  // Low PW bits of the product of extended operands equal the full product.
  assign a_x    = {{DATA_W{(SIGNED != 0) & in_a[DATA_W-1]}}, in_a};
  assign b_x    = {{DATA_W{(SIGNED != 0) & in_b[DATA_W-1]}}, in_b};
  assign prod_w = a_x * b_x;

  if (ACC_W > PW) begin : g_prod_ext
    assign prod = {{(ACC_W - PW){(SIGNED != 0) & prod_w[PW-1]}}, prod_w};
  end else begin : g_prod_eq
    assign prod = prod_w;
  end

  // The first operand after a last starts a fresh tile from zero.
  assign acc_base = (state == FLUSH) ? '0 : acc;

`ifdef PE_SAT_EN
  sat_res_t         sr;
  logic [SAT_W-1:0] acc_x;
  logic [SAT_W-1:0] prod_x;

  assign acc_x   = {{(SAT_W - ACC_W){(SIGNED != 0) & acc_base[ACC_W-1]}}, acc_base};
  assign prod_x  = {{(SAT_W - ACC_W){(SIGNED != 0) & prod[ACC_W-1]}}, prod};
  assign sr      = sat_add(acc_x, prod_x, SIGNED != 0, ACC_W);
  assign acc_sum = ACC_W'(sr.sum);
  assign sum_sat = sr.sat;
`else
  assign acc_sum = acc_base + prod;
  assign sum_sat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      state <= ACC;
      if (in_valid && in_last) begin
        state <= FLUSH;
        acc   <= '0;
        // A hold draining on this edge frees room for the new sum.
        if (!hold_full || hold_take) begin
          hold      <= acc_sum;
          hold_full <= 1'b1;
        end else begin
          err_ovf <= 1'b1;
        end
      end else begin
        if (in_valid) begin
          acc <= acc_sum;
        end
        if (hold_take) begin
          hold_full <= 1'b0;
        end
      end
      if (in_valid && sum_sat) begin
        err_ovf <= 1'b1;
      end
    end
  end

  pe_res_slot #(
    .ACC_W (ACC_W)
  ) u_slot (
    .clk       (clk),
    .rst       (rst),
    .loc_valid (hold_full),
    .loc_data  (hold),
    .loc_take  (hold_take),
    .up_valid  (res_in_valid),
    .up_data   (res_in_data),
    .up_ready  (res_in_ready),
    .out_valid (res_out_valid),
    .out_data  (res_out_data),
    .out_ready (res_out_ready)
  );

endmodule
